result_buffer_q: RTL and testbench
==================================

Name: result_buffer_q

Overview:
- Parametrised successor to the single-channel-format result handler.
- Accepts per-pixel accumulator vectors (NUM_CH channels) from the systolic array via valid/ready.
- Per channel: adds bias, applies optional ReLU, requantises with rounding shift and saturation, then stores into per-channel banks in pixel-generation order.
- Provides a 1-cycle-latency readback port for the bench or the next layer's loader, plus a saturation counter.

Parameters:
- NUM_CH, 6, number of output channels / banks
- ACC_W, 32, accumulator input width (signed)
- OUT_W, 16, stored result width (signed)
- DEPTH, 576, pixels per bank
- SHIFT_W, 5, width of requantisation shift field
- ADDR_W, $clog2(DEPTH), pixel address width

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_async_i  in  1  asynchronous, active-high reset
- start_i  in  1  pulse; latches cfg_* and begins a run
- cfg_num_pix_i  in  ADDR_W+1  pixels expected this run (0..DEPTH)
- cfg_shift_i  in  SHIFT_W  arithmetic right shift applied after bias
- cfg_relu_en_i  in  1  1 = clamp negatives to 0 after bias
- bias_i  in  NUM_CH*ACC_W  signed bias per channel; latched at start_i
- in_valid_i  in  1  input vector valid
- in_ready_o  out  1  block can accept a vector
- in_data_i  in  NUM_CH*ACC_W  signed accumulators; channel c at bits [c*ACC_W +: ACC_W]
- rd_en_i  in  1  readback request
- rd_ch_i  in  $clog2(NUM_CH)  readback channel
- rd_addr_i  in  ADDR_W  readback pixel index
- rd_data_o  out  OUT_W  readback data
- rd_valid_o  out  1  rd_data_o valid
- busy_o  out  1  run in progress
- done_o  out  1  one-cycle pulse when all pixels are written
- sat_cnt_o  out  16  count of saturated elements this run

Behaviour:
- Reset values: all outputs 0; FSM IDLE; counters 0; latched config 0. Bank contents are not cleared.
- FSM states:
  - IDLE --start_i--> RUN. If latched cfg_num_pix_i == 0, go IDLE --start_i--> DONE directly.
  - RUN: accepts vectors. Move to DRAIN after the cfg_num_pix-th accepted vector.
  - DRAIN: waits until the pipeline is empty (2 cycles), then moves to DONE.
  - DONE: asserts done_o for 1 cycle, then returns to IDLE.
- busy_o = 1 in RUN, DRAIN and DONE.
- start_i outside IDLE is ignored. A new start clears sat_cnt_o and the write pointer.
- Handshake:
  - in_ready_o = (state==RUN) && (accepted < num_pix).
  - Transfer occurs when in_valid_i && in_ready_o.
  - in_data_i may change freely while in_valid_i is low.
  - No combinational path from in_valid_i to in_ready_o.
- Pipeline per channel (write latency is 2 cycles after transfer):
  - S1: b = sext(in) + sext(bias), ACC_W+1 bits. If relu_en and b < 0, b = 0.
  - S2: if shift > 0, r = (b + (1 << (shift-1))) >>> shift (round half up); else r = b. Then saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - S2 write: bank[c][wptr] = r. wptr increments once per vector.
  - sat_cnt_o increments by the number of channels saturated in that vector, and sticks at 0xFFFF.
- Readback:
  - rd_data_o and rd_valid_o are registered 1 cycle after rd_en_i. rd_valid_o = rd_en_i delayed 1 cycle.
  - Reads are allowed in any state.
  - Same-cycle read and write to the same bank/address returns the old data.
  - rd_addr_i >= DEPTH or rd_ch_i >= NUM_CH returns 0, with rd_valid_o still 1.
- Reset mid-run: everything returns to reset values immediately. An in-flight pipeline write is discarded.
- done_o and the S2 write of the final vector never occur in the same cycle; done_o comes at least 1 cycle later.

Test Plan:
- Basic: NUM_CH=6, num_pix=4, shift=0, relu off, bias 0; inputs ch c = 10*i + c → readback bank[2][3] = 32; done_o pulses once; sat_cnt_o = 0.
- Bias+ReLU: bias ch0 = -100, relu on; inputs 50 and 150 → bank[0][0] = 0, bank[0][1] = 50.
- Rounding: shift=4; inputs 24, 23, -24 → 2, 1, -1 (values are -24+8=-16, >>>4 = -1).
- Saturation: OUT_W=16, shift=0; inputs 40000 and -40000 on all 6 channels → 32767 and -32768; sat_cnt_o = 12.
- Backpressure/bounds: num_pix=3 with in_valid_i held high for 10 cycles → exactly 3 transfers; in_ready_o low after the 3rd; start_i pulsed mid-run is ignored; num_pix=0 → done_o 1 cycle after start, no writes.
- Reset/readback: assert rst_async_i after 2 of 5 vectors → outputs 0, FSM IDLE; a following run of 5 completes normally. Read of rd_addr_i = DEPTH → rd_data_o = 0, rd_valid_o = 1.

Source files
------------

// File: rtl/result_buffer_q.sv
// result_buffer_q
// Post-processing and storage stage behind the systolic array.
// Each accepted vector of NUM_CH signed accumulators goes through
// bias add, optional ReLU, rounding right shift and saturation.
// Each channel result is written into its own bank at the next
// pixel address, in pixel-generation order.
// A registered readback port returns stored results, and a sticky
// counter records how many elements saturated during the current run.
//
// Ports:
//   clk_i, rst_async_i        clock (rising edge); async active-high reset
//   start_i                   pulse in IDLE: latch cfg_* / bias_i, begin run
//   cfg_num_pix_i             pixels expected this run (0..DEPTH)
//   cfg_shift_i               arithmetic right shift applied after bias
//   cfg_relu_en_i             clamp negative biased values to zero
//   bias_i                    per-channel signed bias, channel c at [c*ACC_W +: ACC_W]
//   in_valid_i/in_ready_o     input vector handshake
//   in_data_i                 per-channel signed accumulators
//   rd_en_i/rd_ch_i/rd_addr_i readback request (channel, pixel)
//   rd_data_o/rd_valid_o      readback data, one cycle after rd_en_i
//   busy_o                    run in progress (RUN/DRAIN/DONE)
//   done_o                    one-cycle pulse once every pixel is written
//   sat_cnt_o                 saturated elements this run, sticks at 0xFFFF
module result_buffer_q #(
  parameter int NUM_CH  = 6,
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 16,
  parameter int DEPTH   = 576,
  parameter int SHIFT_W = 5,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_async_i,
  input  logic                    start_i,
  input  logic [ADDR_W:0]         cfg_num_pix_i,
  input  logic [SHIFT_W-1:0]      cfg_shift_i,
  input  logic                    cfg_relu_en_i,
  input  logic [NUM_CH*ACC_W-1:0] bias_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [NUM_CH*ACC_W-1:0] in_data_i,
  input  logic                    rd_en_i,
  input  logic [CH_W-1:0]         rd_ch_i,
  input  logic [ADDR_W-1:0]       rd_addr_i,
  output logic [OUT_W-1:0]        rd_data_o,
  output logic                    rd_valid_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [15:0]             sat_cnt_o
);

  localparam int EXT_W = ACC_W + 2;  // biased value plus rounding headroom

  // Saturation limits expressed at the extended width
  localparam logic signed [EXT_W-1:0] SAT_MAX =
    {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN =
    {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [CH_W:0]   NCH_W   = (CH_W+1)'(NUM_CH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t                  state_reg;
  logic [ADDR_W:0]         num_pix_reg;
  logic [ADDR_W:0]         acc_cnt_reg;
  logic [SHIFT_W-1:0]      shift_reg;
  logic                    relu_reg;
  logic [NUM_CH*ACC_W-1:0] bias_reg;
  logic                    busy_reg;
  logic                    done_reg;
  logic [ADDR_W-1:0]       wptr_reg;
  logic [15:0]             sat_cnt_reg;
  logic                    s1_valid_reg;
  logic                    s2_valid_reg;

  logic                    in_ready;
  logic                    xfer;
  logic [NUM_CH-1:0]       sat_vec;
  logic [15:0]             sat_add;
  logic [16:0]             sat_sum;
  logic [15:0]             sat_cnt_next;

  logic                    rd_addr_ok;
  logic                    rd_ch_ok;
  logic                    rd_valid_reg;
  logic                    rd_ok_reg;
  logic [CH_W-1:0]         rd_ch_reg;
  logic [NUM_CH-1:0][OUT_W-1:0] rd_q_vec;
  logic [OUT_W-1:0]        rd_data;

  // Ready depends only on registered state, never on in_valid_i
  assign in_ready = (state_reg == ST_RUN) && (acc_cnt_reg < num_pix_reg);
  assign xfer     = in_valid_i && in_ready;

  assign rd_addr_ok = ({1'b0, rd_addr_i} < DEPTH_W);
  assign rd_ch_ok   = ({1'b0, rd_ch_i} < NCH_W);

  // ------------------------------------------------------------------
  // Per-channel datapath and bank
  // ------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [ACC_W-1:0]        in_ch;
    logic [ACC_W-1:0]        bias_ch;
    logic signed [ACC_W:0]   b_sum;
    logic signed [ACC_W:0]   b_relu;
    logic signed [ACC_W:0]   s1_b_reg;
    logic signed [EXT_W-1:0] b_ext;
    logic signed [EXT_W-1:0] rnd_add;
    logic signed [EXT_W-1:0] rnd_sum;
    logic signed [EXT_W-1:0] shifted;
    logic                    over;
    logic                    under;
    logic [OUT_W-1:0]        r_next;
    logic [OUT_W-1:0]        s2_r_reg;
    logic                    s2_sat_reg;
    logic [OUT_W-1:0]        mem [DEPTH];
    logic [OUT_W-1:0]        rd_q;

    assign in_ch   = in_data_i[gi*ACC_W +: ACC_W];
    assign bias_ch = bias_reg[gi*ACC_W +: ACC_W];

    // S1: bias add at ACC_W+1 bits so the sum cannot wrap, then ReLU
    always_comb begin
      b_sum  = $signed({in_ch[ACC_W-1], in_ch}) + $signed({bias_ch[ACC_W-1], bias_ch});
      b_relu = (relu_reg && b_sum[ACC_W]) ? '0 : b_sum;
    end

    // S2: round half up by adding half an LSB before the arithmetic shift,
    // then clamp to the OUT_W signed range
    always_comb begin
      b_ext   = {s1_b_reg[ACC_W], s1_b_reg};
      rnd_add = '0;
      if (shift_reg != '0) begin
        rnd_add = EXT_W'(1) << (shift_reg - SHIFT_W'(1));
      end
      rnd_sum = b_ext + rnd_add;
      shifted = rnd_sum >>> shift_reg;
      over    = (shifted > SAT_MAX);
      under   = (shifted < SAT_MIN);
      if (over) begin
        r_next = {1'b0, {(OUT_W-1){1'b1}}};
      end else if (under) begin
        r_next = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
        r_next = shifted[OUT_W-1:0];
      end
    end

    always_ff @(posedge clk_i or posedge rst_async_i) begin
      if (rst_async_i) begin
        s1_b_reg   <= '0;
        s2_r_reg   <= '0;
        s2_sat_reg <= 1'b0;
      end else begin
        if (xfer) begin
          s1_b_reg <= b_relu;
        end
        if (s1_valid_reg) begin
          s2_r_reg   <= r_next;
          s2_sat_reg <= over || under;
        end
      end
    end

    assign sat_vec[gi] = s2_sat_reg;

    // Bank: contents survive reset. A read colliding with the write
    // returns the previous contents (read-before-write).
    always_ff @(posedge clk_i) begin
      if (s2_valid_reg) begin
        mem[wptr_reg] <= s2_r_reg;
      end
      if (rd_en_i && rd_addr_ok) begin
        rd_q <= mem[rd_addr_i];
      end
    end

    assign rd_q_vec[gi] = rd_q;
  end

  // ------------------------------------------------------------------
  // Saturation counting for the vector being written this cycle
  // ------------------------------------------------------------------
  always_comb begin
    sat_add = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sat_add = sat_add + 16'(sat_vec[c]);
    end
    sat_sum      = {1'b0, sat_cnt_reg} + {1'b0, sat_add};
    sat_cnt_next = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end

  // ------------------------------------------------------------------
  // Control FSM, pipeline valids, write pointer and counters
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_async_i) begin
    if (rst_async_i) begin
      state_reg    <= ST_IDLE;
      num_pix_reg  <= '0;
      acc_cnt_reg  <= '0;
      shift_reg    <= '0;
      relu_reg     <= 1'b0;
      bias_reg     <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      wptr_reg     <= '0;
      sat_cnt_reg  <= '0;
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else begin
      done_reg     <= 1'b0;
      s1_valid_reg <= xfer;
      s2_valid_reg <= s1_valid_reg;

      if (s2_valid_reg) begin
        wptr_reg    <= wptr_reg + ADDR_W'(1);
        sat_cnt_reg <= sat_cnt_next;
      end

      case (state_reg)
        ST_IDLE: begin
          // The pipeline is always empty in IDLE, so these clears
          // never race a pending write.
          if (start_i) begin
            num_pix_reg <= cfg_num_pix_i;
            shift_reg   <= cfg_shift_i;
            relu_reg    <= cfg_relu_en_i;
            bias_reg    <= bias_i;
            acc_cnt_reg <= '0;
            wptr_reg    <= '0;
            sat_cnt_reg <= '0;
            busy_reg    <= 1'b1;
            if (cfg_num_pix_i == '0) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (xfer) begin
            acc_cnt_reg <= acc_cnt_reg + (ADDR_W+1)'(1);
            if ((acc_cnt_reg + (ADDR_W+1)'(1)) == num_pix_reg) begin
              state_reg <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Leave only once both stages are empty, which puts done_o
          // at least one cycle after the final bank write.
          if (!s1_valid_reg && !s2_valid_reg) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Readback: every bank reads in parallel, the channel is picked after
  // the RAM register. Out-of-range requests still report valid, data 0.
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_async_i) begin
    if (rst_async_i) begin
      rd_valid_reg <= 1'b0;
      rd_ok_reg    <= 1'b0;
      rd_ch_reg    <= '0;
    end else begin
      rd_valid_reg <= rd_en_i;
      rd_ok_reg    <= rd_en_i && rd_addr_ok && rd_ch_ok;
      rd_ch_reg    <= rd_ch_i;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_ok_reg) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (rd_ch_reg == CH_W'(c)) begin
          rd_data = rd_q_vec[c];
        end
      end
    end
  end

  assign in_ready_o = in_ready;
  assign rd_data_o  = rd_data;
  assign rd_valid_o = rd_valid_reg;
  assign busy_o     = busy_reg;
  assign done_o     = done_reg;
  assign sat_cnt_o  = sat_cnt_reg;

endmodule

// File: tb/tb_result_buffer_q.sv
// Testbench for result_buffer_q: directed runs checked against an
// arithmetic model of the per-element transform and bank contents.
module tb_result_buffer_q;

  localparam int NUM_CH  = 6;
  localparam int ACC_W   = 32;
  localparam int OUT_W   = 16;
  localparam int DEPTH   = 576;
  localparam int SHIFT_W = 5;
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int CH_W    = $clog2(NUM_CH);

  logic                    clk;
  logic                    rst;
  logic                    start;
  logic [ADDR_W:0]         cfg_num_pix;
  logic [SHIFT_W-1:0]      cfg_shift;
  logic                    cfg_relu_en;
  logic [NUM_CH*ACC_W-1:0] bias;
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_CH*ACC_W-1:0] in_data;
  logic                    rd_en;
  logic [CH_W-1:0]         rd_ch;
  logic [ADDR_W-1:0]       rd_addr;
  logic [OUT_W-1:0]        rd_data;
  logic                    rd_valid;
  logic                    busy;
  logic                    done;
  logic [15:0]             sat_cnt;

  result_buffer_q #(
    .NUM_CH(NUM_CH), .ACC_W(ACC_W), .OUT_W(OUT_W), .DEPTH(DEPTH),
    .SHIFT_W(SHIFT_W), .ADDR_W(ADDR_W), .CH_W(CH_W)
  ) dut (
    .clk_i(clk), .rst_async_i(rst), .start_i(start),
    .cfg_num_pix_i(cfg_num_pix), .cfg_shift_i(cfg_shift),
    .cfg_relu_en_i(cfg_relu_en), .bias_i(bias),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .rd_en_i(rd_en), .rd_ch_i(rd_ch), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .busy_o(busy), .done_o(done), .sat_cnt_o(sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     total = 0;
  int     bad   = 0;
  longint model_bank [NUM_CH][DEPTH];
  int     model_wptr = 0;
  longint model_sat  = 0;
  longint cur_bias [NUM_CH];
  int     cur_shift = 0;
  bit     cur_relu  = 1'b0;
  longint vec [NUM_CH];
  longint exp_q [$];
  string  tag_q [$];
  int     xfer_cnt = 0;
  int     done_cnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Element transform from its arithmetic definition
  function automatic longint model_elem(input longint x, input longint b,
                                        input int sh, input bit relu,
                                        output bit sat);
    longint v;
    longint hi;
    longint lo;
    hi  = (longint'(1) << (OUT_W-1)) - 1;
    lo  = -(longint'(1) << (OUT_W-1));
    v   = x + b;
    if (relu && v < 0) v = 0;
    if (sh > 0) v = (v + (longint'(1) << (sh-1))) >>> sh;
    sat = 1'b0;
    if (v > hi) begin v = hi; sat = 1'b1; end
    if (v < lo) begin v = lo; sat = 1'b1; end
    return v;
  endfunction

  // Model update on each accepted vector and output checks
  always @(negedge clk) begin
    int     nsat;
    bit     s;
    longint x;
    if (in_valid && in_ready) begin
      xfer_cnt++;
      nsat = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        x = longint'($signed(in_data[c*ACC_W +: ACC_W]));
        model_bank[c][model_wptr] = model_elem(x, cur_bias[c], cur_shift, cur_relu, s);
        nsat += int'(s);
      end
      model_sat = model_sat + nsat;
      if (model_sat > 65535) model_sat = 65535;
      model_wptr++;
    end
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected_valid", 1, 0);
      end else begin
        chk(tag_q.pop_front(), longint'($signed(rd_data)), exp_q.pop_front());
      end
    end
    if (done) begin
      done_cnt++;
      chk("sat_cnt_at_done", longint'(sat_cnt), model_sat);
      chk("busy_at_done", longint'(busy), 1);
    end
  end

  task automatic do_start(input int num, input int sh, input bit relu);
    cfg_num_pix = (ADDR_W+1)'(num);
    cfg_shift   = SHIFT_W'(sh);
    cfg_relu_en = relu;
    for (int c = 0; c < NUM_CH; c++) bias[c*ACC_W +: ACC_W] = cur_bias[c][ACC_W-1:0];
    cur_shift  = sh;
    cur_relu   = relu;
    model_wptr = 0;
    model_sat  = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_vec();
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < NUM_CH; c++) in_data[c*ACC_W +: ACC_W] = vec[c][ACC_W-1:0];
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("send_accepted", longint'(ok), 1);
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk(name, longint'(seen), 1);
    @(posedge clk); #1;
  endtask

  task automatic rd(input int ch, input int addr);
    rd_en   = 1'b1;
    rd_ch   = CH_W'(ch);
    rd_addr = ADDR_W'(addr);
    if (ch < NUM_CH && addr < DEPTH) exp_q.push_back(model_bank[ch][addr]);
    else exp_q.push_back(0);
    tag_q.push_back($sformatf("rd ch%0d addr%0d", ch, addr));
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  // Literal expectation: pins the model and the DUT to the same constant
  task automatic rd_lit(input int ch, input int addr, input longint lit);
    chk($sformatf("model ch%0d addr%0d", ch, addr), model_bank[ch][addr], lit);
    rd_en   = 1'b1;
    rd_ch   = CH_W'(ch);
    rd_addr = ADDR_W'(addr);
    exp_q.push_back(lit);
    tag_q.push_back($sformatf("rd_lit ch%0d addr%0d", ch, addr));
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic rd_all(input int n);
    for (int c = 0; c < NUM_CH; c++)
      for (int a = 0; a < n; a++) rd(c, a);
  endtask

  task automatic drain_reads();
    repeat (3) @(posedge clk);
    #1;
    chk("rd_queue_empty", exp_q.size(), 0);
  endtask

  task automatic clear_bias();
    for (int c = 0; c < NUM_CH; c++) cur_bias[c] = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int xb;
    int db;
    rst = 1'b1; start = 1'b0; cfg_num_pix = '0; cfg_shift = '0; cfg_relu_en = 1'b0;
    bias = '0; in_valid = 1'b0; in_data = '0; rd_en = 1'b0; rd_ch = '0; rd_addr = '0;
    clear_bias();
    for (int c = 0; c < NUM_CH; c++) vec[c] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_rd_valid", longint'(rd_valid), 0);
    chk("rst_rd_data", longint'(rd_data), 0);
    chk("rst_sat_cnt", longint'(sat_cnt), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic: ch c = 10*i + c
    clear_bias();
    do_start(4, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < NUM_CH; c++) vec[c] = 10*i + c;
      send_vec();
    end
    wait_done("basic_done");
    chk("basic_done_count", done_cnt, 1);
    chk("basic_sat_cnt", longint'(sat_cnt), 0);
    chk("basic_busy_after", longint'(busy), 0);
    rd_lit(2, 3, 32);
    rd_all(4);
    drain_reads();

    // Bias + ReLU
    clear_bias();
    cur_bias[0] = -100;
    do_start(2, 0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < NUM_CH; c++) vec[c] = (i == 0) ? -5*c : 7*c;
      vec[0] = (i == 0) ? 50 : 150;
      send_vec();
    end
    wait_done("relu_done");
    rd_lit(0, 0, 0);
    rd_lit(0, 1, 50);
    rd_all(2);
    drain_reads();

    // Rounding with shift 4
    clear_bias();
    cur_bias[1] = 3;
    do_start(3, 4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < NUM_CH; c++) vec[c] = 100*c - 300 + 7*i;
      vec[0] = (i == 0) ? 24 : (i == 1) ? 23 : -24;
      send_vec();
    end
    wait_done("round_done");
    rd_lit(0, 0, 2);
    rd_lit(0, 1, 1);
    rd_lit(0, 2, -1);
    rd_all(3);
    drain_reads();

    // Saturation on every channel, both directions
    clear_bias();
    do_start(2, 0, 1'b0);
    for (int c = 0; c < NUM_CH; c++) vec[c] = 40000;
    send_vec();
    for (int c = 0; c < NUM_CH; c++) vec[c] = -40000;
    send_vec();
    wait_done("sat_done");
    chk("sat_model_literal", model_sat, 12);
    chk("sat_cnt_literal", longint'(sat_cnt), 12);
    rd_lit(3, 0, 32767);
    rd_lit(3, 1, -32768);
    drain_reads();

    // Zero-pixel run: done right after start, counters cleared, no writes
    do_start(0, 0, 1'b0);
    @(negedge clk);
    chk("zero_done_pulse", longint'(done), 1);
    chk("zero_sat_cleared", longint'(sat_cnt), 0);
    @(negedge clk);
    chk("zero_done_low", longint'(done), 0);
    chk("zero_busy_low", longint'(busy), 0);
    @(posedge clk); #1;
    rd_lit(3, 0, 32767);
    rd_lit(5, 1, -32768);
    drain_reads();

    // Backpressure / ignored mid-run start
    clear_bias();
    do_start(3, 0, 1'b0);
    xb = xfer_cnt;
    db = done_cnt;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      for (int c = 0; c < NUM_CH; c++) in_data[c*ACC_W +: ACC_W] = ACC_W'(1000 + 10*k + c);
      if (k == 1) begin
        start = 1'b1;
        cfg_num_pix = (ADDR_W+1)'(7);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("bp_transfers", xfer_cnt - xb, 3);
    chk("bp_in_ready_low", longint'(in_ready), 0);
    chk("bp_done_once", done_cnt - db, 1);
    chk("bp_busy_low", longint'(busy), 0);
    @(posedge clk); #1;
    rd_lit(1, 2, 1021);
    rd_all(3);
    drain_reads();

    // Reset in the middle of a run
    clear_bias();
    do_start(5, 0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < NUM_CH; c++) vec[c] = 500 + i;
      send_vec();
    end
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_in_ready", longint'(in_ready), 0);
    chk("midrst_done", longint'(done), 0);
    chk("midrst_rd_valid", longint'(rd_valid), 0);
    chk("midrst_sat_cnt", longint'(sat_cnt), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_idle_busy", longint'(busy), 0);

    // Follow-up full run after reset
    clear_bias();
    cur_bias[4] = -7;
    do_start(5, 1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < NUM_CH; c++) vec[c] = 3*i - c;
      send_vec();
    end
    wait_done("final_done");
    rd_all(5);
    rd(0, DEPTH);
    @(negedge clk);
    chk("oor_addr_valid", longint'(rd_valid), 1);
    @(posedge clk); #1;
    rd(NUM_CH, 0);
    drain_reads();

    chk("total_done_pulses", done_cnt, 7);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
